uart_rx_fifo: RTL and testbench

Oversampling UART receiver with an 8N1 framing checker and a first-word-fall-through receive FIFO. It sits between the external `rx` pin and the CPU's memory-mapped I/O logic. It replaces single-sample-per-bit reception with 16x mid-bit sampling, and it buffers bytes so that software polling latency does not drop characters. Framing and overrun errors are sticky flags that the host clears.

---
 rtl/uart_rx_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 16x-oversampling 8N1 UART receiver feeding a first-word-fall-through FIFO.
// Framing and overrun errors are sticky until the host clears them.
module uart_rx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   baud_max,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          clear_err
);

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] SC_MID  = 4'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  logic               w_rxs;

  logic [15:0]        r_tick_cnt;
  logic [15:0]        w_baud_eff;
  logic               w_tick;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_sc;
  logic [3:0]         w_sc_nxt;
  logic [2:0]         r_bi;
  logic [2:0]         w_bi_nxt;
  logic               w_sample;
  logic               w_push_req;
  logic               w_ferr_set;
  logic [DATA_W-1:0]  r_shift;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_ovr_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // Free-running sample tick; a baud_max of 0 behaves as 1 (tick every cycle).
  assign w_baud_eff = (baud_max == 16'd0) ? 16'd1 : baud_max;
  assign w_tick     = (r_tick_cnt == (w_baud_eff - 16'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= 16'd0;
    end else if (w_tick) begin
      r_tick_cnt <= 16'd0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sc    <= 4'd0;
      r_bi    <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_bi    <= w_bi_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_bi_nxt    = r_bi;
    w_sample    = 1'b0;
    w_push_req  = 1'b0;
    w_ferr_set  = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = S_START;
            w_sc_nxt    = 4'd0;
          end
        end
        S_START: begin
          if (r_sc == SC_MID) begin
            w_sc_nxt = 4'd0;
            if (!w_rxs) begin
              w_state_nxt = S_DATA;
              w_bi_nxt    = 3'd0;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        S_DATA: begin
          if (r_sc == SC_LAST) begin
            w_sample = 1'b1;
            w_sc_nxt = 4'd0;
            if (r_bi == 3'd7) begin
              w_state_nxt = S_STOP;
            end else begin
              w_bi_nxt = r_bi + 3'd1;
            end
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        S_STOP: begin
          if (r_sc == SC_LAST) begin
            w_sc_nxt = 4'd0;
            if (w_rxs) begin
              w_push_req  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_set  = 1'b1;
              w_state_nxt = S_BREAK;
            end
          end else begin
            w_sc_nxt = r_sc + 4'd1;
          end
        end
        S_BREAK: begin
          // Wait for the line to return high so a held-low line yields one error, not a stream of frames.
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_sc_nxt    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_sample) begin
      r_shift[r_bi] <= w_rxs;
    end
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = rd_en & ~w_empty;
  assign w_push    = w_push_req & (~w_full | w_pop);
  assign w_ovr_set = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  assign count    = r_wr_ptr - r_rd_ptr;
  assign rd_valid = ~w_empty;
  assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // A set in the same cycle as clear_err wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_ferr_set | (frame_err & ~clear_err);
      overrun   <= w_ovr_set  | (overrun   & ~clear_err);
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus corner-case sequences.
module tb_uart_rx_fifo;

  localparam int BAUD = 4;
  localparam int BIT  = 16 * BAUD;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud_max;
  logic        rx;
  logic        rd_en;
  logic        clear_err;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        frame_err;
  logic        overrun;

  int checks = 0;
  int errors = 0;
  int cyc;
  int lat_ref;
  int lat;

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  uart_rx_fifo #(.FIFO_DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .baud_max  (baud_max),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frames start aligned to the tick phase so the stop-sample cycle is repeatable.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int act_at,
                            input int act_sel, output int l);
    logic [9:0] bits;
    logic [3:0] c0;
    int n;
    bits = {stop, d, 1'b0};
    rx = 1'b1;
    repeat (16) @(negedge clk);
    while (cyc % BAUD != 0) @(negedge clk);
    c0 = count;
    l  = -1;
    n  = 0;
    for (int k = 0; k < 10; k++) begin
      rx = bits[k];
      repeat (BIT) begin
        @(negedge clk);
        n++;
        if (l < 0 && count != c0) l = n;
        rd_en     = (act_sel == 1) && (n + 1 == act_at);
        clear_err = (act_sel == 2) && (n + 1 == act_at);
      end
    end
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clr();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    baud_max  = 16'(BAUD);
    rx        = 1'b1;
    rd_en     = 1'b0;
    clear_err = 1'b0;
    lat_ref   = 612;

    vecs[0] = '{d: 8'hA5, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{d: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{d: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{d: 8'h81, stop: 1'b0, exp_valid: 1'b0, exp_data: 8'h00, exp_ferr: 1'b1};
    vecs[4] = '{d: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
    vecs[5] = '{d: 8'h6A, stop: 1'b1, exp_valid: 1'b1, exp_data: 8'h6A, exp_ferr: 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, 0, 0, lat);
      if (i == 0) begin
        lat_ref = lat;
        chk("basic_latency_bound", (lat > 0 && lat <= 614), 1);
      end
      chk("vec_rd_valid", rd_valid, vecs[i].exp_valid);
      chk("vec_count", count, vecs[i].exp_valid ? 1 : 0);
      if (vecs[i].exp_valid) chk("vec_rd_data", rd_data, vecs[i].exp_data);
      chk("vec_frame_err", frame_err, vecs[i].exp_ferr);
      chk("vec_overrun", overrun, 0);
      if (vecs[i].exp_valid) begin
        pop();
        chk("vec_pop_rd_valid", rd_valid, 0);
        chk("vec_pop_count", count, 0);
      end
      if (vecs[i].exp_ferr) begin
        clr();
        chk("vec_clear_frame_err", frame_err, 0);
      end
    end

    // Short low glitch must not produce a byte.
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * BAUD) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("glitch_count", count, 0);
    chk("glitch_frame_err", frame_err, 0);
    send_frame(8'h3C, 1'b1, 0, 0, lat);
    chk("after_glitch_count", count, 1);
    chk("after_glitch_data", rd_data, 8'h3C);
    pop();

    // Frame error followed by a long break.
    send_frame(8'h81, 1'b0, 0, 0, lat);
    repeat (40 * BIT) @(negedge clk);
    chk("break_frame_err", frame_err, 1);
    chk("break_count", count, 0);
    chk("break_rd_valid", rd_valid, 0);
    send_frame(8'h55, 1'b1, 0, 0, lat);
    chk("post_break_count", count, 1);
    chk("post_break_data", rd_data, 8'h55);
    clr();
    chk("break_cleared", frame_err, 0);
    pop();

    // Overrun: nine bytes into eight entries with no reads.
    for (int b = 0; b < 9; b++) begin
      send_frame(8'(b), 1'b1, 0, 0, lat);
      if (b == 7) begin
        chk("fill_count", count, 8);
        chk("fill_no_overrun", overrun, 0);
      end
    end
    chk("overrun_count", count, 8);
    chk("overrun_flag", overrun, 1);
    for (int i = 0; i < 8; i++) begin
      chk("overrun_pop_data", rd_data, i);
      pop();
    end
    chk("overrun_drained", rd_valid, 0);
    clr();
    chk("overrun_cleared", overrun, 0);

    // Full FIFO, pop on the same edge as the push of 8'hEE.
    for (int b = 0; b < 8; b++) send_frame(8'h10 + 8'(b), 1'b1, 0, 0, lat);
    chk("full_count", count, 8);
    send_frame(8'hEE, 1'b1, lat_ref, 1, lat);
    chk("pushpop_overrun", overrun, 0);
    chk("pushpop_count", count, 8);
    for (int i = 0; i < 8; i++) begin
      chk("pushpop_data", rd_data, (i < 7) ? (32'h11 + i) : 32'hEE);
      pop();
    end
    chk("pushpop_drained", count, 0);

    // clear_err in the same cycle as a frame error: set wins.
    chk("collide_pre", frame_err, 0);
    send_frame(8'h81, 1'b0, lat_ref, 2, lat);
    chk("collide_frame_err", frame_err, 1);

    // Reset in the middle of the data bits of 8'hF0.
    send_frame(8'h5A, 1'b1, 0, 0, lat);
    chk("pre_reset_count", count, 1);
    rx = 1'b1;
    repeat (16) @(negedge clk);
    while (cyc % BAUD != 0) @(negedge clk);
    rx = 1'b0;
    repeat (3 * BIT + BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_rd_valid", rd_valid, 0);
    chk("midreset_count", count, 0);
    chk("midreset_rd_data", rd_data, 8'h00);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_overrun", overrun, 0);
    repeat (BIT / 2 + BIT) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b1;
    repeat (5 * BIT) @(negedge clk);
    chk("post_reset_count", count, 0);
    chk("post_reset_rd_valid", rd_valid, 0);
    send_frame(8'h96, 1'b1, 0, 0, lat);
    chk("post_reset_frame_count", count, 1);
    chk("post_reset_frame_data", rd_data, 8'h96);
    chk("post_reset_frame_err", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
